// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
package uart_tx_arb_pkg;
  localparam int BYTE_W = 8;
  localparam int REQ_N  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GUARD  = 2'd3
  } state_t;
endpackage

// File: rtl/uart_tx_arb_pick.sv
// Winner select for two requesters; fixed priority to 0, or round-robin with UART_TX_ARB_ROUND_ROBIN_EN.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module uart_tx_arb_pick
  import uart_tx_arb_pkg::*;
(
  input  logic [REQ_N-1:0] valid,
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  input  logic             last_grant,
`endif
  output logic             any_valid,
  output logic             winner
);

  always_comb begin
    any_valid = |valid;
    winner    = ~valid[0];
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    // On contention hand the byte to whoever did not win last time.
    if (&valid) winner = ~last_grant;
`endif
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two requesters (UART_TX_ARB_ROUND_ROBIN_EN selects round-robin).
// Latency: ack 1 clk after valid sampled, tx_go 1 clk later; GUARD_CYCLES idle clocks after each byte.
// Backpressure: requesters hold valid/byte until ack; WAIT aborts after TIMEOUT_CYCLES without tx_done.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [BYTE_W-1:0] req0_byte,
  input  logic [BYTE_W-1:0] req1_byte,
  output logic              req0_ack,
  output logic              req1_ack,
  input  logic              tx_done,
  output logic              tx_go,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              grant_id,
  output logic              busy,
  output logic              timeout
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GRD_W = ($clog2(GUARD_CYCLES + 1) > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GRD_W-1:0]   grd_q, grd_d;
  logic [REQ_N-1:0]   ack_q, ack_d;
  logic               go_d, timeout_d, grant_d;
  logic [BYTE_W-1:0]  byte_d;
  logic               any_valid, winner;

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  logic               last_grant_q, last_grant_d;
`endif

  uart_tx_arb_pick u_pick (
    .valid      ({req1_valid, req0_valid}),
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .any_valid  (any_valid),
    .winner     (winner)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grd_d     = grd_q;
    ack_d     = '0;
    go_d      = 1'b0;
    timeout_d = 1'b0;
    byte_d    = tx_byte;
    grant_d   = grant_id;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          byte_d        = winner ? req1_byte : req0_byte;
          grant_d       = winner;
          ack_d[winner] = 1'b1;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
          last_grant_d  = winner;
`endif
          state_d       = LAUNCH;
        end
      end
      LAUNCH: begin
        go_d    = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion landing on the terminal count wins over the abort.
        if (tx_done || (cnt_q == CNT_LAST)) begin
          timeout_d = ~tx_done;
          grd_d     = '0;
          state_d   = (GUARD_CYCLES == 0) ? IDLE : GUARD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GUARD: begin
        if (grd_q == GRD_LAST) state_d = IDLE;
        else                   grd_d   = grd_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      grd_q    <= '0;
      ack_q    <= '0;
      tx_go    <= 1'b0;
      timeout  <= 1'b0;
      tx_byte  <= '0;
      grant_id <= 1'b0;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grd_q    <= grd_d;
      ack_q    <= ack_d;
      tx_go    <= go_d;
      timeout  <= timeout_d;
      tx_byte  <= byte_d;
      grant_id <= grant_d;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign req0_ack = ack_q[0];
  assign req1_ack = ack_q[1];
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter; build with UART_TX_ARB_ROUND_ROBIN_EN for round-robin.
module tb_uart_tx_arbiter;
  localparam int TO = 16;
  localparam int GC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_byte = 8'h00, req1_byte = 8'h00;
  logic       req0_ack, req1_ack;
  logic       tx_done = 1'b0;
  logic       tx_go;
  logic [7:0] tx_byte;
  logic       grant_id, busy, timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.GUARD_CYCLES(GC), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_byte  (req0_byte),
    .req1_byte  (req1_byte),
    .req0_ack   (req0_ack),
    .req1_ack   (req1_ack),
    .tx_done    (tx_done),
    .tx_go      (tx_go),
    .tx_byte    (tx_byte),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout    (timeout)
  );

  typedef struct {
    int         id;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   model_last = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference rule: contention goes to 0 (fixed) or to the requester that did not win last.
  function automatic int pick_model(input bit v0, input bit v1);
    if (v0 && v1) begin
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
      return model_last ? 0 : 1;
`else
      return 0;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (req0_ack || req1_ack)) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {30'b0, req1_ack, req0_ack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_line", {30'b0, req1_ack, req0_ack}, (e.id != 0) ? 32'd2 : 32'd1);
        chk("ack_grant", {31'b0, grant_id}, e.id);
        chk("ack_byte", {24'b0, tx_byte}, {24'b0, e.b});
      end
    end
  end

  // d = WAIT cycle (counter value) on which tx_done is sampled; d < 0 never completes.
  task automatic run_xfer(input bit v0, input bit v1, input logic [7:0] b0, input logic [7:0] b1,
                          input int d, input bit stray, input bit hold, output int g);
    int   w;
    exp_t e;
    if (stray) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tx_done    = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk("stray_idle_busy", {31'b0, busy}, 32'd0);
    end
    w = pick_model(v0, v1);
    model_last = w[0];
    e.id = w;
    e.b  = (w != 0) ? b1 : b0;
    exp_q.push_back(e);
    req0_valid = v0;
    req1_valid = v1;
    req0_byte  = b0;
    req1_byte  = b1;
    @(negedge clk);
    chk("ack_seen", {31'b0, req0_ack | req1_ack}, 32'd1);
    chk("ack_cycle_go", {31'b0, tx_go}, 32'd0);
    chk("launch_busy", {31'b0, busy}, 32'd1);
    if (!hold) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    if (stray) tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("go_pulse", {31'b0, tx_go}, 32'd1);
    chk("go_byte", {24'b0, tx_byte}, {24'b0, e.b});
    chk("go_grant", {31'b0, grant_id}, w);
    g = int'(grant_id);
    for (int j = 0; j < TO; j++) begin
      if (d == j) tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      if (j == 0) chk("go_single", {31'b0, tx_go}, 32'd0);
      chk("timeout", {31'b0, timeout}, {31'b0, (d < 0) && (j == TO - 1)});
      chk("wait_busy", {31'b0, busy}, 32'd1);
      chk("byte_hold", {24'b0, tx_byte}, {24'b0, e.b});
      if (d == j) break;
    end
    if (stray) tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("guard_busy", {31'b0, busy}, 32'd1);
    chk("guard_no_timeout", {31'b0, timeout}, 32'd0);
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int g, v, d;
    int rr_exp[4];
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    rr_exp = '{0, 1, 0, 1};
`else
    rr_exp = '{0, 0, 0, 0};
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst_go", {31'b0, tx_go}, 32'd0);
    chk("rst_ack", {30'b0, req1_ack, req0_ack}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_byte", {24'b0, tx_byte}, 32'd0);
    chk("rst_grant", {31'b0, grant_id}, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention with both valids held across transfers.
    for (int i = 0; i < 4; i++) begin
      run_xfer(1'b1, 1'b1, 8'h30, 8'h61, 3 + i, 1'b0, 1'b1, g);
      chk("contention_grant", g, rr_exp[i]);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    run_xfer(1'b1, 1'b0, 8'h41, 8'h00, 13, 1'b0, 1'b0, g);
    run_xfer(1'b0, 1'b1, 8'h7E, 8'hC3, -1, 1'b0, 1'b0, g);
    run_xfer(1'b1, 1'b0, 8'h55, 8'h00, TO - 1, 1'b0, 1'b0, g);
    run_xfer(1'b0, 1'b1, 8'h00, 8'h99, 4, 1'b1, 1'b0, g);

    for (int i = 0; i < 24; i++) begin
      v = int'($urandom_range(1, 3));
      d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      run_xfer(v[0], v[1], 8'($urandom), 8'($urandom), d,
               $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, g);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of WAIT.
    exp_q.push_back('{0, 8'h5A});
    req0_valid = 1'b1;
    req0_byte  = 8'h5A;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_go", {31'b0, tx_go}, 32'd0);
    chk("midrst_ack", {30'b0, req1_ack, req0_ack}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_byte", {24'b0, tx_byte}, 32'd0);
    chk("midrst_grant", {31'b0, grant_id}, 32'd0);
    chk("midrst_timeout", {31'b0, timeout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_go", {31'b0, tx_go}, 32'd0);
      chk("post_rst_ack", {30'b0, req1_ack, req0_ack}, 32'd0);
      chk("post_rst_busy", {31'b0, busy}, 32'd0);
    end
    run_xfer(1'b1, 1'b1, 8'hA5, 8'h5A, 2, 1'b0, 1'b0, g);
    chk("post_rst_contention", g, 0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
